// File: rtl/sys_bus_pkg.sv
// ---------------------------------------------------------------------------
// sys_bus_pkg
//   Shared types and constants for the system bus bridge.
//   - bus_state_t   : bridge FSM state encoding
//   - CTRL_NONE     : rd/wr control code meaning "no access"
//   - MAX_SLV       : upper bound on the slave count
//   - slv_map_t     : base/mask table, one 64-bit entry per possible slave
//   - default_base / default_mask : 4 KiB windows from 0x2000_0000 upwards
// ---------------------------------------------------------------------------
package sys_bus_pkg;

    localparam int unsigned MAX_SLV   = 16;
    localparam logic [2:0]  CTRL_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_t;

    // Table is sized for MAX_SLV entries of 64 bits; a bridge only looks at
    // its first NUM_SLV entries and the low ADDR_W bits of each.
    typedef logic [MAX_SLV-1:0][63:0] slv_map_t;

    function automatic slv_map_t default_base();
        slv_map_t m;
        for (int i = 0; i < MAX_SLV; i++) begin
            m[i] = 64'h2000_0000 + 64'(i) * 64'h1000;
        end
        return m;
    endfunction

    function automatic slv_map_t default_mask();
        slv_map_t m;
        for (int i = 0; i < MAX_SLV; i++) begin
            m[i] = 64'hFFFF_FFFF_FFFF_F000;
        end
        return m;
    endfunction

endpackage

// File: rtl/sys_bus_bridge_decoder.sv
// ---------------------------------------------------------------------------
// sys_bus_decoder
//   Combinational address decoder. Slave i hits when
//   (addr & mask[i]) == base[i]; with overlapping windows the lowest index
//   wins, so sel_o is always one-hot or zero.
//   Ports:
//     addr_i  in   ADDR_W   address to decode
//     sel_o   out  NUM_SLV  one-hot slave select
//     hit_o   out  1        some slave matched
// ---------------------------------------------------------------------------
module sys_bus_decoder
    import sys_bus_pkg::*;
#(
    parameter int unsigned NUM_SLV  = 4,
    parameter int unsigned ADDR_W   = 64,
    parameter slv_map_t    SLV_BASE = default_base(),
    parameter slv_map_t    SLV_MASK = default_mask()
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               hit_o
);

    logic found;

    always_comb begin
        sel_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found &&
                ((addr_i & SLV_MASK[i][ADDR_W-1:0]) == SLV_BASE[i][ADDR_W-1:0])) begin
                sel_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/sys_bus_bridge.sv
// ---------------------------------------------------------------------------
// sys_bus_bridge
//   Connects one bus master to NUM_SLV req/ack slaves. A command is latched
//   in IDLE, the selected slave is requested until it acks or the request
//   times out, and the master sees a one-cycle m_ready_o pulse (with m_err_o
//   for unmapped addresses, rd+wr together, or timeouts).
//   Ports:
//     clk_i, rst_ni       clock, async active-low reset
//     m_addr_i/m_din_i    master address / write data
//     m_rd_ctrl_i         read code  (000 = none)
//     m_wr_ctrl_i         write code (000 = none)
//     m_dout_o            read data, valid with m_ready_o
//     m_ready_o/m_err_o   completion pulse / error flag
//     s_req_o             one-hot slave request
//     s_addr_o/s_wdata_o  latched address / write data to all slaves
//     s_rd_ctrl_o/s_wr_ctrl_o latched control codes to all slaves
//     s_rdata_i           packed slave read data, slave i at [i*DATA_W +: DATA_W]
//     s_ack_i             slave done strobes
//
//   state | meaning
//   IDLE  | waiting for a command; decode and latch on arrival
//   REQ   | s_req held to selected slave; count cycles toward TIMEOUT
//   RESP  | m_ready pulse, no error
//   ERR   | m_ready pulse with m_err, m_dout forced to 0
// ---------------------------------------------------------------------------
module sys_bus_bridge
    import sys_bus_pkg::*;
#(
    parameter int unsigned NUM_SLV  = 4,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TIMEOUT  = 255,
    parameter slv_map_t    SLV_BASE = default_base(),
    parameter slv_map_t    SLV_MASK = default_mask()
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_W-1:0]         m_addr_i,
    input  logic [DATA_W-1:0]         m_din_i,
    input  logic [2:0]                m_rd_ctrl_i,
    input  logic [2:0]                m_wr_ctrl_i,
    output logic [DATA_W-1:0]         m_dout_o,
    output logic                      m_ready_o,
    output logic                      m_err_o,
    output logic [NUM_SLV-1:0]        s_req_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [2:0]                s_rd_ctrl_o,
    output logic [2:0]                s_wr_ctrl_o,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_SLV-1:0]        s_ack_i
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_SLV-1:0]  s_req_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_wdata_q;
    logic [2:0]          s_rd_ctrl_q;
    logic [2:0]          s_wr_ctrl_q;
    logic [DATA_W-1:0]   m_dout_q;
    logic                m_ready_q;
    logic                m_err_q;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_hit;
    logic                cmd_valid;
    logic                cmd_both;
    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;

    sys_bus_decoder #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr_i (m_addr_i),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    assign cmd_valid = (m_rd_ctrl_i != CTRL_NONE) || (m_wr_ctrl_i != CTRL_NONE);
    assign cmd_both  = (m_rd_ctrl_i != CTRL_NONE) && (m_wr_ctrl_i != CTRL_NONE);

    // s_req_q is non-zero only in REQ, so it doubles as the ack/rdata select
    // and keeps acks from other slaves or other states out of the FSM.
    assign ack_sel = |(s_ack_i & s_req_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s_req_q[i]) begin
                rdata_sel = rdata_sel | s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_req_q     <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_rd_ctrl_q <= CTRL_NONE;
            s_wr_ctrl_q <= CTRL_NONE;
            m_dout_q    <= '0;
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        s_addr_q    <= m_addr_i;
                        s_wdata_q   <= m_din_i;
                        s_rd_ctrl_q <= m_rd_ctrl_i;
                        s_wr_ctrl_q <= m_wr_ctrl_i;
                        if (cmd_both || !dec_hit) begin
                            state_q   <= ST_ERR;
                            m_ready_q <= 1'b1;
                            m_err_q   <= 1'b1;
                            m_dout_q  <= '0;
                        end else begin
                            state_q <= ST_REQ;
                            s_req_q <= dec_sel;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the final counted cycle still completes normally.
                    if (ack_sel) begin
                        state_q   <= ST_RESP;
                        s_req_q   <= '0;
                        m_ready_q <= 1'b1;
                        m_err_q   <= 1'b0;
                        if (s_rd_ctrl_q != CTRL_NONE) begin
                            m_dout_q <= rdata_sel;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_ERR;
                        s_req_q   <= '0;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        m_ready_q <= 1'b1;
                        m_err_q   <= 1'b1;
                        m_dout_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP, ST_ERR: begin
                    state_q   <= ST_IDLE;
                    m_ready_q <= 1'b0;
                    m_err_q   <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_req_q   <= '0;
                    m_ready_q <= 1'b0;
                    m_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s_req_o     = s_req_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign s_rd_ctrl_o = s_rd_ctrl_q;
    assign s_wr_ctrl_o = s_wr_ctrl_q;
    assign m_dout_o    = m_dout_q;
    assign m_ready_o   = m_ready_q;
    assign m_err_o     = m_err_q;

endmodule

// File: tb/tb_sys_bus_bridge.sv
module tb_sys_bus_bridge;

    function automatic sys_bus_pkg::slv_map_t overlap_base();
        sys_bus_pkg::slv_map_t m;
        m    = sys_bus_pkg::default_base();
        m[2] = m[0];
        return m;
    endfunction

    localparam sys_bus_pkg::slv_map_t OV_BASE = overlap_base();

    logic         clk;
    logic         rst_n;

    logic [63:0]  m_addr, m_din, m_dout;
    logic [2:0]   m_rd, m_wr, s_rd, s_wr;
    logic         m_ready, m_err;
    logic [3:0]   s_req, s_ack;
    logic [63:0]  s_addr, s_wdata;
    logic [255:0] s_rdata;

    logic [63:0]  ov_addr, ov_din, ov_dout;
    logic [2:0]   ov_rd, ov_wr, ov_srd, ov_swr;
    logic         ov_ready, ov_err;
    logic [3:0]   ov_req, ov_ack;
    logic [63:0]  ov_saddr, ov_swdata;
    logic [255:0] ov_rdata;

    int tests = 0;
    int fails = 0;

    sys_bus_bridge #(.NUM_SLV(4), .ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_addr_i(m_addr), .m_din_i(m_din), .m_rd_ctrl_i(m_rd), .m_wr_ctrl_i(m_wr),
        .m_dout_o(m_dout), .m_ready_o(m_ready), .m_err_o(m_err),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_rd_ctrl_o(s_rd), .s_wr_ctrl_o(s_wr),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack)
    );

    sys_bus_bridge #(.NUM_SLV(4), .ADDR_W(64), .DATA_W(64), .TIMEOUT(8),
                     .SLV_BASE(OV_BASE)) dut_ov (
        .clk_i(clk), .rst_ni(rst_n),
        .m_addr_i(ov_addr), .m_din_i(ov_din), .m_rd_ctrl_i(ov_rd), .m_wr_ctrl_i(ov_wr),
        .m_dout_o(ov_dout), .m_ready_o(ov_ready), .m_err_o(ov_err),
        .s_req_o(ov_req), .s_addr_o(ov_saddr), .s_wdata_o(ov_swdata),
        .s_rd_ctrl_o(ov_srd), .s_wr_ctrl_o(ov_swr),
        .s_rdata_i(ov_rdata), .s_ack_i(ov_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got req/rdy/err=%b expected 000000", {s_req, m_ready, m_err});
        end
        tests++;
        if ({m_dout, s_addr, s_wdata, s_rd, s_wr} !== 198'b0) begin
            fails++;
            $display("FAIL reset_data: got dout=%h addr=%h wdata=%h rd=%b wr=%b expected all 0",
                     m_dout, s_addr, s_wdata, s_rd, s_wr);
        end
        tests++;
        if ({ov_req, ov_ready, ov_err, ov_dout} !== 70'b0) begin
            fails++;
            $display("FAIL reset_ov: got req=%b rdy=%b err=%b dout=%h expected 0",
                     ov_req, ov_ready, ov_err, ov_dout);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_wait_read();
        m_addr = 64'h2000_1008;
        m_rd   = 3'b001;
        s_rdata[1*64 +: 64] = 64'hDEAD_BEEF;
        step();
        tests++;
        if ({s_req, m_ready} !== 5'b0010_0) begin
            fails++;
            $display("FAIL zw_req: got req=%b rdy=%b expected req=0010 rdy=0", s_req, m_ready);
        end
        tests++;
        if (s_addr !== 64'h2000_1008 || s_rd !== 3'b001) begin
            fails++;
            $display("FAIL zw_saddr: got addr=%h rd=%b expected 20001008/001", s_addr, s_rd);
        end
        s_ack = 4'b0010;
        step();
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0000_10 || m_dout !== 64'hDEAD_BEEF) begin
            fails++;
            $display("FAIL zw_resp: got req=%b rdy=%b err=%b dout=%h expected 0000/1/0/deadbeef",
                     s_req, m_ready, m_err, m_dout);
        end
        m_rd  = 3'b000;
        s_ack = 4'b0000;
        step();
        tests++;
        if ({s_req, m_ready} !== 5'b0) begin
            fails++;
            $display("FAIL zw_idle: got req=%b rdy=%b expected 0/0", s_req, m_ready);
        end
    endtask

    task automatic test_wait_write();
        m_addr = 64'h2000_3000;
        m_din  = 64'h55;
        m_wr   = 3'b010;
        s_rdata[3*64 +: 64] = 64'h0BAD_0BAD;
        step();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (s_req !== 4'b1000 || s_wdata !== 64'h55 || s_wr !== 3'b010 ||
                s_addr !== 64'h2000_3000 || m_ready !== 1'b0) begin
                fails++;
                $display("FAIL ww_hold[%0d]: got req=%b wdata=%h wr=%b addr=%h rdy=%b expected 1000/55/010/20003000/0",
                         i, s_req, s_wdata, s_wr, s_addr, m_ready);
            end
            if (i == 5) s_ack = 4'b1000;
            step();
        end
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0000_10 || m_dout !== 64'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ww_resp: got req=%b rdy=%b err=%b dout=%h expected 0000/1/0/deadbeef",
                     s_req, m_ready, m_err, m_dout);
        end
        m_wr  = 3'b000;
        s_ack = 4'b0000;
        step();
        tests++;
        if (m_ready !== 1'b0) begin
            fails++;
            $display("FAIL ww_once: got rdy=%b expected 0", m_ready);
        end
    endtask

    task automatic test_unmapped();
        m_addr = 64'h3000_0000;
        m_rd   = 3'b001;
        step();
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0000_11 || m_dout !== 64'h0) begin
            fails++;
            $display("FAIL unmapped: got req=%b rdy=%b err=%b dout=%h expected 0000/1/1/0",
                     s_req, m_ready, m_err, m_dout);
        end
        m_rd = 3'b000;
        step();
        tests++;
        if ({s_req, m_ready} !== 5'b0) begin
            fails++;
            $display("FAIL unmapped_idle: got req=%b rdy=%b expected 0/0", s_req, m_ready);
        end
    endtask

    task automatic test_timeout();
        m_addr = 64'h2000_0010;
        m_rd   = 3'b001;
        s_rdata[0 +: 64] = 64'h7777;
        step();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (s_req !== 4'b0001 || m_ready !== 1'b0) begin
                fails++;
                $display("FAIL to_req[%0d]: got req=%b rdy=%b expected 0001/0", i, s_req, m_ready);
            end
            step();
        end
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0000_11 || m_dout !== 64'h0) begin
            fails++;
            $display("FAIL to_err: got req=%b rdy=%b err=%b dout=%h expected 0000/1/1/0",
                     s_req, m_ready, m_err, m_dout);
        end
        m_rd = 3'b000;
        step();
        s_ack = 4'b0001;
        step();
        s_ack = 4'b0000;
        tests++;
        if ({s_req, m_ready, m_err} !== 6'b0 || m_dout !== 64'h0) begin
            fails++;
            $display("FAIL to_late_ack: got req=%b rdy=%b err=%b dout=%h expected 0",
                     s_req, m_ready, m_err, m_dout);
        end
        step();
        tests++;
        if ({s_req, m_ready} !== 5'b0) begin
            fails++;
            $display("FAIL to_late_ack2: got req=%b rdy=%b expected 0", s_req, m_ready);
        end
    endtask

    task automatic test_async_reset();
        m_addr = 64'h2000_1000;
        m_rd   = 3'b001;
        step();
        step();
        step();
        tests++;
        if (s_req !== 4'b0010) begin
            fails++;
            $display("FAIL ar_pre: got req=%b expected 0010", s_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({s_req, m_ready} !== 5'b0 || s_addr !== 64'h0) begin
            fails++;
            $display("FAIL ar_drop: got req=%b rdy=%b addr=%h expected 0/0/0", s_req, m_ready, s_addr);
        end
        m_rd = 3'b000;
        step();
        rst_n = 1'b1;
        step();
        m_addr = 64'h2000_2040;
        m_rd   = 3'b011;
        s_rdata[2*64 +: 64] = 64'h1234_5678_9ABC_DEF0;
        step();
        tests++;
        if (s_req !== 4'b0100 || s_rd !== 3'b011) begin
            fails++;
            $display("FAIL ar_new_req: got req=%b rd=%b expected 0100/011", s_req, s_rd);
        end
        step();
        s_ack = 4'b0100;
        step();
        tests++;
        if ({m_ready, m_err} !== 2'b10 || m_dout !== 64'h1234_5678_9ABC_DEF0) begin
            fails++;
            $display("FAIL ar_new_resp: got rdy=%b err=%b dout=%h expected 1/0/123456789abcdef0",
                     m_ready, m_err, m_dout);
        end
        m_rd  = 3'b000;
        s_ack = 4'b0000;
        step();
    endtask

    task automatic test_overlap_and_illegal();
        ov_addr = 64'h2000_0004;
        ov_rd   = 3'b001;
        ov_rdata[0 +: 64]    = 64'hA5;
        ov_rdata[2*64 +: 64] = 64'h5A;
        step();
        tests++;
        if (ov_req !== 4'b0001) begin
            fails++;
            $display("FAIL ov_prio: got req=%b expected 0001", ov_req);
        end
        ov_ack = 4'b0101;
        step();
        tests++;
        if ({ov_ready, ov_err} !== 2'b10 || ov_dout !== 64'hA5) begin
            fails++;
            $display("FAIL ov_resp: got rdy=%b err=%b dout=%h expected 1/0/a5", ov_ready, ov_err, ov_dout);
        end
        ov_rd  = 3'b000;
        ov_ack = 4'b0000;
        step();
        ov_rd = 3'b001;
        ov_wr = 3'b001;
        ov_addr = 64'h2000_0000;
        step();
        tests++;
        if ({ov_req, ov_ready, ov_err} !== 6'b0000_11 || ov_dout !== 64'h0) begin
            fails++;
            $display("FAIL ov_both: got req=%b rdy=%b err=%b dout=%h expected 0000/1/1/0",
                     ov_req, ov_ready, ov_err, ov_dout);
        end
        ov_rd = 3'b000;
        ov_wr = 3'b000;
        step();
        tests++;
        if ({ov_req, ov_ready} !== 5'b0) begin
            fails++;
            $display("FAIL ov_idle: got req=%b rdy=%b expected 0/0", ov_req, ov_ready);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_addr  = '0;  m_din  = '0;  m_rd  = '0;  m_wr  = '0;
        s_rdata = '0;  s_ack  = '0;
        ov_addr = '0;  ov_din = '0;  ov_rd = '0;  ov_wr = '0;
        ov_rdata = '0; ov_ack = '0;
        #1;
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_unmapped();
        test_timeout();
        test_async_reset();
        test_overlap_and_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
